// File: rtl/tim_banked.sv
// Word-interleaved banked TIM: instruction read port plus data read/write port, round-robin on bank collisions.
// Optional per-byte even parity storage and error reporting when TIM_PARITY_EN is defined.
module tim_banked #(
  parameter int TIM_DEPTH = 1024,
  parameter int TIM_WIDTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  output logic        i_err,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err
);
  localparam int BW = $clog2(TIM_WIDTH);
  localparam int DW = $clog2(TIM_DEPTH);
  localparam int IW = DW + BW;

  logic [31:0]   mem [TIM_WIDTH][TIM_DEPTH];

  logic          i_pend_q, i_pend_d;
  logic          d_pend_q, d_pend_d;
  logic          rr_q, rr_d;
  logic          i_ready_q, i_ready_d;
  logic          d_ready_q, d_ready_d;
  logic [IW-1:0] i_pidx_q, i_pidx_d;
  logic [IW-1:0] d_pidx_q, d_pidx_d;
  logic [31:0]   d_pwdata_q, d_pwdata_d;
  logic [3:0]    d_pwstrb_q, d_pwstrb_d;
  logic [31:0]   i_rdata_q, d_rdata_q;

  logic          i_act, d_act, coll, i_wins, i_gnt, d_gnt;
  logic [IW-1:0] i_idx, d_idx;
  logic [31:0]   d_req_wdata;
  logic [3:0]    d_req_wstrb;
  logic [BW-1:0] i_bank, d_bank;
  logic [DW-1:0] i_row, d_row;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], i_addr[31:IW+2], d_addr[1:0], d_addr[31:IW+2]};

  always_comb begin
    // A pending request replaces the port's input; a new pulse during pending is ignored.
    i_act       = reset & (i_pend_q | i_valid);
    d_act       = reset & (d_pend_q | d_valid);
    i_idx       = i_pend_q ? i_pidx_q : i_addr[IW+1:2];
    d_idx       = d_pend_q ? d_pidx_q : d_addr[IW+1:2];
    d_req_wdata = d_pend_q ? d_pwdata_q : d_wdata;
    d_req_wstrb = d_pend_q ? d_pwstrb_q : d_wstrb;
    i_bank      = i_idx[BW-1:0];
    d_bank      = d_idx[BW-1:0];
    i_row       = i_idx[IW-1:BW];
    d_row       = d_idx[IW-1:BW];

    coll   = i_act & d_act & (i_bank == d_bank);
    i_wins = i_pend_q | (~d_pend_q & rr_q);
    i_gnt  = i_act & ~(coll & ~i_wins);
    d_gnt  = d_act & ~(coll & i_wins);

    i_pend_d   = i_act & ~i_gnt;
    d_pend_d   = d_act & ~d_gnt;
    i_pidx_d   = i_idx;
    d_pidx_d   = d_idx;
    d_pwdata_d = d_req_wdata;
    d_pwstrb_d = d_req_wstrb;
    rr_d       = coll ? ~rr_q : rr_q;
    i_ready_d  = i_gnt;
    d_ready_d  = d_gnt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      i_pend_q  <= 1'b0;
      d_pend_q  <= 1'b0;
      rr_q      <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
    end else begin
      i_pend_q  <= i_pend_d;
      d_pend_q  <= d_pend_d;
      rr_q      <= rr_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
    end
  end

  always_ff @(posedge clock) begin
    i_pidx_q   <= i_pidx_d;
    d_pidx_q   <= d_pidx_d;
    d_pwdata_q <= d_pwdata_d;
    d_pwstrb_q <= d_pwstrb_d;
  end

`ifdef TIM_PARITY_EN
  logic [3:0] par [TIM_WIDTH][TIM_DEPTH];
  logic [3:0] i_par_q, d_par_q;

  function automatic logic [3:0] byte_par(input logic [31:0] w);
    logic [3:0] p;
    for (int b = 0; b < 4; b++) p[b] = ^w[8*b +: 8];
    return p;
  endfunction
`endif

  // Bank access: the read register samples the word before this cycle's byte writes land.
  always_ff @(posedge clock) begin
    if (d_gnt) begin
      d_rdata_q <= mem[d_bank][d_row];
`ifdef TIM_PARITY_EN
      d_par_q   <= par[d_bank][d_row];
`endif
      for (int b = 0; b < 4; b++) begin
        if (d_req_wstrb[b]) begin
          mem[d_bank][d_row][8*b +: 8] <= d_req_wdata[8*b +: 8];
`ifdef TIM_PARITY_EN
          par[d_bank][d_row][b]        <= ^d_req_wdata[8*b +: 8];
`endif
        end
      end
    end
    if (i_gnt) begin
      i_rdata_q <= mem[i_bank][i_row];
`ifdef TIM_PARITY_EN
      i_par_q   <= par[i_bank][i_row];
`endif
    end
  end

  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign i_rdata = i_ready_q ? i_rdata_q : 32'h0;
  assign d_rdata = d_ready_q ? d_rdata_q : 32'h0;

`ifdef TIM_PARITY_EN
  assign i_err = i_ready_q & (|(i_par_q ^ byte_par(i_rdata_q)));
  assign d_err = d_ready_q & (|(d_par_q ^ byte_par(d_rdata_q)));
`else
  assign i_err = 1'b0;
  assign d_err = 1'b0;
`endif
endmodule
